weight_fetcher: RTL and testbench

- Sequencer between weight memory and the systolic array.
- On a start command it walks the weight memory from a base address, one 4-weight tile (a full 2x2 PE set) per address step.
- Each tile is registered and presented to the array over a valid/ready handshake.
- Drives the memory's combinational read address and consumes its four weight outputs.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/weight_fetcher.sv | 133 +++++++++++++
 tb/tb_weight_fetcher.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the weight fetch path.
package tpu_pkg;

   localparam int unsigned WF_ADDR_W = 13;
   localparam int unsigned WF_DATA_W = 8;
   localparam int unsigned WF_CNT_W  = 8;
   localparam int unsigned WF_STRIDE = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/weight_fetcher.sv
// Walks weight memory from a base address and streams 4-weight tiles
// to the systolic array over a valid/ready handshake.
module weight_fetcher
   import tpu_pkg::*;
#(
   parameter int unsigned ADDR_W = WF_ADDR_W,
   parameter int unsigned DATA_W = WF_DATA_W,
   parameter int unsigned CNT_W  = WF_CNT_W,
   parameter int unsigned STRIDE = WF_STRIDE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_tiles,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_w0,
   input  logic [DATA_W-1:0] mem_w1,
   input  logic [DATA_W-1:0] mem_w2,
   input  logic [DATA_W-1:0] mem_w3,
   output logic              tile_valid,
   input  logic              tile_ready,
   output logic [DATA_W-1:0] tile_w0,
   output logic [DATA_W-1:0] tile_w1,
   output logic [DATA_W-1:0] tile_w2,
   output logic [DATA_W-1:0] tile_w3,
   output logic              busy,
   output logic              done
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] addr_reg;
   logic [CNT_W-1:0]  num_reg;
   logic [CNT_W-1:0]  issue_cnt;
   logic              load_cmd;
   logic              fetch;
   logic              clear_valid;

   assign mem_addr = addr_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath enables; flush overrides everything.
   always_comb begin
      state_nxt   = state;
      load_cmd    = 1'b0;
      fetch       = 1'b0;
      clear_valid = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_tiles != '0) begin
                     load_cmd  = 1'b1;
                     state_nxt = RUN;
                  end else begin
                     state_nxt = DONE;
                  end
               end
            end
            RUN: begin
               // A new tile may be loaded when the slot is empty or being drained now.
               if (!tile_valid || tile_ready) begin
                  fetch = 1'b1;
                  if (issue_cnt + CNT_W'(1) == num_reg) begin
                     state_nxt = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (tile_valid && tile_ready) begin
                  clear_valid = 1'b1;
                  state_nxt   = DONE;
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Command capture, address walk and tile register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg   <= '0;
         num_reg    <= '0;
         issue_cnt  <= '0;
         tile_valid <= 1'b0;
         tile_w0    <= '0;
         tile_w1    <= '0;
         tile_w2    <= '0;
         tile_w3    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
         if (flush) begin
            tile_valid <= 1'b0;
         end else if (load_cmd) begin
            addr_reg  <= base_addr;
            num_reg   <= num_tiles;
            issue_cnt <= '0;
         end else if (fetch) begin
            tile_w0    <= mem_w0;
            tile_w1    <= mem_w1;
            tile_w2    <= mem_w2;
            tile_w3    <= mem_w3;
            tile_valid <= 1'b1;
            addr_reg   <= addr_reg + ADDR_W'(STRIDE);
            issue_cnt  <= issue_cnt + CNT_W'(1);
         end else if (clear_valid) begin
            tile_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_weight_fetcher.sv
// Self-checking bench: a behavioural weight memory plus a tile scoreboard.
module tb_weight_fetcher;

   localparam int unsigned AW     = 13;
   localparam int unsigned DW     = 8;
   localparam int unsigned CW     = 8;
   localparam int          STRIDE = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] num_tiles;
   logic          flush;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_w0, mem_w1, mem_w2, mem_w3;
   logic          tile_valid;
   logic          tile_ready;
   logic [DW-1:0] tile_w0, tile_w1, tile_w2, tile_w3;
   logic          busy;
   logic          done;
   logic [31:0]   tile_now;

   logic [DW-1:0] mem [8192];

   int          n_checks = 0;
   int          n_err    = 0;
   int          n_xfer   = 0;
   int          n_done   = 0;
   logic [31:0] sb[$];

   // Weight memory: four bytes from the current address, combinational, wrapping.
   assign mem_w0   = mem[mem_addr];
   assign mem_w1   = mem[mem_addr + 13'd1];
   assign mem_w2   = mem[mem_addr + 13'd2];
   assign mem_w3   = mem[mem_addr + 13'd3];
   assign tile_now = {tile_w3, tile_w2, tile_w1, tile_w0};

   always #5 clk = ~clk;

   weight_fetcher dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .num_tiles  (num_tiles),
      .flush      (flush),
      .mem_addr   (mem_addr),
      .mem_w0     (mem_w0),
      .mem_w1     (mem_w1),
      .mem_w2     (mem_w2),
      .mem_w3     (mem_w3),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .tile_w0    (tile_w0),
      .tile_w1    (tile_w1),
      .tile_w2    (tile_w2),
      .tile_w3    (tile_w3),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input int i);
      return AW'(int'(b) + STRIDE * i);
   endfunction

   function automatic logic [31:0] tile_at(input logic [AW-1:0] a);
      logic [AW-1:0] x;
      logic [31:0]   t;
      t = '0;
      for (int j = 0; j < 4; j++) begin
         x = a + AW'(j);
         t[8*j +: 8] = mem[x];
      end
      return t;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score transfers and handshake stability across the edge.
   task automatic step();
      logic          pre_xfer;
      logic          pre_stall;
      logic [31:0]   pre_tile;
      logic [AW-1:0] pre_addr;
      pre_xfer  = tile_valid && tile_ready && !flush && !rst;
      pre_stall = tile_valid && !tile_ready && !flush && !rst;
      pre_tile  = tile_now;
      pre_addr  = mem_addr;
      @(posedge clk);
      #1;
      if (pre_xfer) begin
         n_xfer++;
         if (sb.size() == 0) begin
            check("xfer_unexpected", 32'd1, 32'd0);
         end else begin
            check("xfer_data", pre_tile, sb.pop_front());
         end
      end
      if (pre_stall) begin
         check("stall_valid", 32'(tile_valid), 32'd1);
         check("stall_tile", tile_now, pre_tile);
         check("stall_addr", 32'(mem_addr), 32'(pre_addr));
      end
      if (done) n_done++;
   endtask

   task automatic start_cmd(input logic [AW-1:0] b, input int n);
      start     = 1'b1;
      base_addr = b;
      num_tiles = CW'(n);
      for (int i = 0; i < n; i++) sb.push_back(tile_at(addr_of(b, i)));
      n_xfer = 0;
      n_done = 0;
      step();
      start     = 1'b0;
      base_addr = AW'($urandom);
      num_tiles = CW'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      check("valid_after_start", 32'(tile_valid), 32'd0);
      if (n > 0) check("addr_after_start", 32'(mem_addr), 32'(b));
   endtask

   // mode 0: ready held high; 1: random ready; 2: ready low for 4 cycles after tile 0.
   task automatic run(input int mode, input logic [AW-1:0] b, input int n);
      logic seen;
      int   lim;
      seen = 1'b0;
      start_cmd(b, n);
      for (int k = 1; k <= 300 && !seen; k++) begin
         case (mode)
            0:       tile_ready = 1'b1;
            1:       tile_ready = 1'($urandom_range(0, 1));
            default: tile_ready = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
         endcase
         start     = (k == 2);
         num_tiles = CW'($urandom_range(1, 9));
         step();
         start = 1'b0;
         if (mode == 0) begin
            lim = (k < n) ? k : n;
            check("stream_addr", 32'(mem_addr), 32'(addr_of(b, lim)));
            check("stream_valid", 32'(tile_valid), 32'(k <= n));
            check("stream_done", 32'(done), 32'(k == n + 1));
            if (k <= n) check("stream_tile", tile_now, tile_at(addr_of(b, k - 1)));
            if (b == 13'h00F && k == 1) check("single_tile", tile_now, 32'h06040503);
         end
         if (mode == 2 && k == 6) begin
            check("bp_tile1_valid", 32'(tile_valid), 32'd1);
            check("bp_tile1_data", tile_now, tile_at(addr_of(b, 1)));
         end
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("xfer_count", 32'(n_xfer), 32'(n));
      check("sb_empty", 32'(sb.size()), 32'd0);
      step();
      check("done_pulse_count", 32'(n_done), 32'd1);
      check("idle_after_done", 32'(busy), 32'd0);
      sb.delete();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      flush      = 1'b0;
      tile_ready = 1'b0;
      base_addr  = '0;
      num_tiles  = '0;
      for (int i = 0; i < 8192; i++) mem[i] = DW'($urandom);
      mem[13'h00F] = 8'd3;
      mem[13'h010] = 8'd5;
      mem[13'h011] = 8'd4;
      mem[13'h012] = 8'd6;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(tile_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_tile", tile_now, 32'd0);
      rst = 1'b0;
      step();

      // Single tile, streaming, address wrap
      run(0, 13'h00F, 1);
      run(0, 13'h000, 3);
      run(0, 13'h1FFE, 3);

      // Backpressure
      run(2, AW'($urandom), 2);

      // Zero count, then start held while in DONE
      start_cmd(AW'($urandom), 0);
      check("zero_done", 32'(done), 32'd1);
      start     = 1'b1;
      num_tiles = 8'd3;
      step();
      start = 1'b0;
      check("zero_idle", 32'(busy), 32'd0);
      check("zero_no_tile", 32'(tile_valid), 32'd0);
      step();
      check("zero_done_count", 32'(n_done), 32'd1);
      check("zero_still_idle", 32'(busy), 32'd0);

      // Flush after two transfers
      start_cmd(13'h0040, 5);
      tile_ready = 1'b1;
      for (int k = 1; k <= 3; k++) step();
      check("flush_xfers_before", 32'(n_xfer), 32'd2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_valid", 32'(tile_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      sb.delete();
      step();
      check("flush_no_done", 32'(n_done), 32'd0);
      check("flush_xfers_after", 32'(n_xfer), 32'd2);
      run(0, 13'h0A00, 2);

      // start and flush together in IDLE: flush wins
      start     = 1'b1;
      flush     = 1'b1;
      num_tiles = 8'd2;
      base_addr = 13'h0123;
      step();
      start = 1'b0;
      flush = 1'b0;
      check("sf_busy", 32'(busy), 32'd0);
      step();
      check("sf_valid", 32'(tile_valid), 32'd0);
      check("sf_still_idle", 32'(busy), 32'd0);

      // Random commands against the scoreboard
      for (int r = 0; r < 6; r++) run(1, AW'($urandom), $urandom_range(1, 6));

      // Async reset while in DRAIN
      tile_ready = 1'b0;
      start_cmd(13'h0200, 1);
      step();
      check("drain_valid", 32'(tile_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(tile_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_tile", tile_now, 32'd0);
      check("arst_addr", 32'(mem_addr), 32'd0);
      #1;
      rst = 1'b0;
      sb.delete();
      tile_ready = 1'b1;
      step();
      step();
      check("arst_no_done", 32'(n_done), 32'd0);
      check("arst_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
